// File: rtl/fetch_ctrl_if.sv
// Request/response bundle between the control decoder and the fetch controller.
interface fetch_ctrl_if #(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned LUT_AW = 4,
   parameter int unsigned CNT_W  = 16
);
   logic              start;
   logic              halt_req;
   logic              stall;
   logic              jump_en;
   logic              branch_en;
   logic              ZERO;
   logic              rel_mode;
   logic [LUT_AW-1:0] lut_idx;
   logic              lut_wr_en;
   logic [LUT_AW-1:0] lut_wr_idx;
   logic [PC_W-1:0]   lut_wr_data;
   logic [PC_W-1:0]   PC;
   logic              halt;
   logic              running;
   logic [CNT_W-1:0]  cycle_ct;
   logic [CNT_W-1:0]  taken_ct;

   modport master (
      output start, halt_req, stall, jump_en, branch_en, ZERO, rel_mode,
             lut_idx, lut_wr_en, lut_wr_idx, lut_wr_data,
      input  PC, halt, running, cycle_ct, taken_ct
   );

   modport slave (
      input  start, halt_req, stall, jump_en, branch_en, ZERO, rel_mode,
             lut_idx, lut_wr_en, lut_wr_idx, lut_wr_data,
      output PC, halt, running, cycle_ct, taken_ct
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: program counter, branch-target LUT, run/halt sequencing
// and saturating execution counters for the 9-bit-instruction processor family.
module fetch_ctrl #(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned LUT_AW = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic        CLK,
   input  logic        reset_n,
   fetch_ctrl_if.slave bus
);
   localparam int unsigned LUT_N = 32'd1 << LUT_AW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  lut_q [LUT_N];
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] taken_q;
   logic             halt_q;
   logic             running_q;

   logic [PC_W-1:0]  lut_rd_c;
   logic [PC_W-1:0]  target_c;
   logic             take_c;

   // Relative targets add the entry as a two's-complement offset; the sum wraps mod 2^PC_W.
   assign lut_rd_c = lut_q[bus.lut_idx];
   assign target_c = bus.rel_mode ? PC_W'(pc_q + lut_rd_c) : lut_rd_c;
   assign take_c   = bus.jump_en | (bus.branch_en & bus.ZERO);

   // Target LUT: read is combinational, so a same-index write lands after the read.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < LUT_N; i++) begin
            lut_q[i] <= '0;
         end
      end else if (bus.lut_wr_en) begin
         lut_q[bus.lut_wr_idx] <= bus.lut_wr_data;
      end
   end

   // Sequencer, PC and counters; start overrides everything in every state.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         cycle_q   <= '0;
         taken_q   <= '0;
         halt_q    <= 1'b0;
         running_q <= 1'b0;
      end else if (bus.start) begin
         state_q   <= ST_RUN;
         pc_q      <= '0;
         cycle_q   <= '0;
         taken_q   <= '0;
         halt_q    <= 1'b0;
         running_q <= 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (cycle_q != '1) begin
                  cycle_q <= cycle_q + CNT_W'(1);
               end
               if (bus.halt_req) begin
                  state_q   <= ST_DONE;
                  halt_q    <= 1'b1;
                  running_q <= 1'b0;
               end else if (bus.stall) begin
                  pc_q <= pc_q;
               end else if (take_c) begin
                  pc_q <= target_c;
                  if (taken_q != '1) begin
                     taken_q <= taken_q + CNT_W'(1);
                  end
               end else begin
                  pc_q <= pc_q + PC_W'(1);
               end
            end
            ST_DONE: begin
               halt_q    <= 1'b1;
               running_q <= 1'b0;
            end
            default: begin
               state_q   <= ST_IDLE;
               halt_q    <= 1'b0;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PC       = pc_q;
   assign bus.halt     = halt_q;
   assign bus.running  = running_q;
   assign bus.cycle_ct = cycle_q;
   assign bus.taken_ct = taken_q;
endmodule
